trace_capture: RTL

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_pkg.sv | 16 +
 rtl/trace_ram.sv | 23 ++
 rtl/trace_capture.sv | 133 +++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and default sizing for the instruction trace capture block.
// Holds the capture FSM state encoding and default WIDTH/DEPTH/POST_TRIG.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_POST_TRIG = 4;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x DW, one synchronous write port, async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module trace_ram #(
  parameter int DW    = 96,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// Circular trace buffer of retired instructions with trigger and readout.
// Ports: clk/reset, arm/abort control, retire record in, trigger match,
// rd_* oldest-first readout, state/done/count/trig_pc status.
module trace_capture
  import trace_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int POST_TRIG = DEF_POST_TRIG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     valid,
  input  logic [WIDTH-1:0]         pc,
  input  logic [WIDTH-1:0]         instr,
  input  logic [WIDTH-1:0]         result,
  input  logic [WIDTH-1:0]         trig_mask,
  input  logic [WIDTH-1:0]         trig_value,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_pc,
  output logic [WIDTH-1:0]         rd_instr,
  output logic [WIDTH-1:0]         rd_result,
  output logic                     rd_last,
  output logic [1:0]               state,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         trig_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t            st, st_nxt;
  logic [AW-1:0]     wr_ptr, rd_ptr, post_cnt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  trig_q;
  logic              match, wr_en, rd_fire, full;
  logic [AW-1:0]     wr_inc;
  logic [CW-1:0]     cnt_inc;
  logic [3*WIDTH-1:0] rdata;

  assign match   = ((instr ^ trig_value) & trig_mask) == '0;
  assign wr_en   = valid && !abort && (st == ARMED || st == POST);
  assign full    = cnt == CW'(DEPTH);
  assign wr_inc  = wr_ptr + AW'(1);
  assign cnt_inc = full ? cnt : cnt + CW'(1);

  assign rd_valid = (st == DONE) && (cnt != '0);
  assign rd_fire  = rd_valid && rd_req;
  assign rd_last  = rd_valid && (cnt == CW'(1));

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:  if (arm) st_nxt = ARMED;
      ARMED: if (valid && match)
               st_nxt = (POST_TRIG == 0) ? DONE : POST;
      POST:  if (valid && post_cnt == AW'(1)) st_nxt = DONE;
      DONE:  if (rd_fire && rd_last) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
    if (abort) st_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st       <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
      cnt      <= '0;
      trig_q   <= '0;
    end else begin
      st <= st_nxt;
      if (abort) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        post_cnt <= '0;
        cnt      <= '0;
      end else if (st == IDLE) begin
        if (arm) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
        end
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_inc;
          cnt    <= cnt_inc;
          // Oldest entry sits count slots behind the write pointer;
          // a full buffer gives zero low bits, i.e. the next write slot.
          if (st_nxt == DONE)
            rd_ptr <= wr_inc - cnt_inc[AW-1:0];
        end
        if (st == ARMED && valid && match) begin
          trig_q   <= pc;
          post_cnt <= AW'(POST_TRIG);
        end
        if (st == POST && valid)
          post_cnt <= post_cnt - AW'(1);
        if (rd_fire) begin
          rd_ptr <= rd_ptr + AW'(1);
          cnt    <= cnt - CW'(1);
        end
      end
    end
  end

  trace_ram #(
    .DW    (3 * WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({pc, instr, result}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign rd_pc     = rdata[3*WIDTH-1:2*WIDTH];
  assign rd_instr  = rdata[2*WIDTH-1:WIDTH];
  assign rd_result = rdata[WIDTH-1:0];

  assign state   = st;
  assign done    = st == DONE;
  assign count   = cnt;
  assign trig_pc = trig_q;

endmodule
